// File: rtl/shift_arbiter.sv
// shift_arbiter: two-port arbiter and sequencer around a shared circular
// rotate unit. The winner's operands are held in registers, rotated in EXEC,
// and the result is returned in a registered dout with a per-port done pulse.
// Optional build macro: SHIFT_ARB_FIXED_PRIO_EN selects fixed priority
// (port 0 always wins). When it is left undefined, arbitration is round-robin.
module shift_arbiter #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [N-1:0] num0,
    input  logic [M-1:0] amt0,
    input  logic         lr0,
    input  logic         req1,
    input  logic [N-1:0] num1,
    input  logic [M-1:0] amt1,
    input  logic         lr1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [N-1:0] dout,
    output logic         busy
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t         state_q;
    logic [N-1:0]   op_num_q;
    logic [M-1:0]   op_amt_q;
    logic           op_lr_q;
    logic           op_port_q;
    logic [N-1:0]   dout_q;
    logic           gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic           last1_q;
`endif

    logic           win1_d;
    logic [N-1:0]   rot_d;
    logic [2*N-1:0] dbl_r, dbl_l;

    // Winner selection among the pending requests.
    always_comb begin
        win1_d = 1'b0;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        win1_d = req1 && !req0;
`else
        // Under contention, the port that was not served last wins.
        win1_d = req1 && (!req0 || !last1_q);
`endif
    end

    // Circular rotate of the latched operand. The word is doubled so that
    // bits shifted out of one half re-enter from the other half.
    always_comb begin
        dbl_r = {op_num_q, op_num_q} >> op_amt_q;
        dbl_l = {op_num_q, op_num_q} << op_amt_q;
        rot_d = op_lr_q ? dbl_l[2*N-1:N] : dbl_r[N-1:0];
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_num_q  <= '0;
            op_amt_q  <= '0;
            op_lr_q   <= 1'b0;
            op_port_q <= 1'b0;
            dout_q    <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            last1_q   <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (req0 || req1) begin
                        op_num_q  <= win1_d ? num1 : num0;
                        op_amt_q  <= win1_d ? amt1 : amt0;
                        op_lr_q   <= win1_d ? lr1  : lr0;
                        op_port_q <= win1_d;
                        gnt0_q    <= !win1_d;
                        gnt1_q    <= win1_d;
                        busy_q    <= 1'b1;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
                        last1_q   <= win1_d;
`endif
                        state_q   <= EXEC;
                    end else begin
                        gnt0_q <= 1'b0;
                        gnt1_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                EXEC: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    dout_q  <= rot_d;
                    done0_q <= !op_port_q;
                    done1_q <= op_port_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign dout  = dout_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (N=16, M=4).
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, lr0, lr1;
    logic [15:0] num0, num1;
    logic [3:0]  amt0, amt1;
    logic        gnt0, gnt1, done0, done1, busy;
    logic [15:0] dout;

    int tests = 0;
    int fails = 0;

    shift_arbiter #(.N(16), .M(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .num0  (num0),
        .amt0  (amt0),
        .lr0   (lr0),
        .req1  (req1),
        .num1  (num1),
        .amt1  (amt1),
        .lr1   (lr1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .dout  (dout),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit circular rotate reference.
    function automatic logic [15:0] ref_rot(input logic [15:0] x, input int unsigned a, input logic left);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (left) r[(i + a) % 16] = x[i];
            else      r[i] = x[(i + a) % 16];
        end
        return r;
    endfunction

    // One isolated operation on a single port with full timing checks.
    task automatic do_op(input string tag, input logic port, input logic [15:0] n,
                         input logic [3:0] a, input logic l, input logic [15:0] exp);
        if (port) begin req1 = 1'b1; num1 = n; amt1 = a; lr1 = l; end
        else      begin req0 = 1'b1; num0 = n; amt0 = a; lr0 = l; end
        step();
        check({tag, " gnt0"}, gnt0, !port);
        check({tag, " gnt1"}, gnt1, port);
        check({tag, " busy_k1"}, busy, 1'b1);
        check({tag, " done_k1"}, {done0, done1}, 2'b00);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        check({tag, " done0"}, done0, !port);
        check({tag, " done1"}, done1, port);
        check({tag, " dout"}, dout, exp);
        check({tag, " busy_k2"}, busy, 1'b0);
        check({tag, " gnt_k2"}, {gnt0, gnt1}, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; lr0 = 0; lr1 = 0;
        num0 = '0; num1 = '0; amt0 = '0; amt1 = '0;
        step();
        step();
        check("reset gnt", {gnt0, gnt1}, 2'b00);
        check("reset done", {done0, done1}, 2'b00);
        check("reset dout", dout, 16'h0000);
        check("reset busy", busy, 1'b0);
        reset = 1'b0;
        step();
        check("idle busy", busy, 1'b0);

        // Single requests with hand-computed results.
        do_op("p0 r4", 1'b0, 16'hFF00, 4'd4, 1'b0, 16'h0FF0);
        step();
        check("dout hold", dout, 16'h0FF0);
        check("done drop", {done0, done1}, 2'b00);
        do_op("p1 l4",  1'b1, 16'hFF00, 4'd4,  1'b1, 16'hF00F);
        do_op("p1 l0",  1'b1, 16'hFF00, 4'd0,  1'b1, 16'hFF00);
        do_op("p1 l15", 1'b1, 16'hFF00, 4'd15, 1'b1, 16'h7F80);
        do_op("p0 r15", 1'b0, 16'h8001, 4'd15, 1'b0, 16'h0003);

        // Amount sweep in both directions against the bit-level reference.
        for (int unsigned a = 0; a < 16; a++) begin
            do_op("sweep r", a[0], 16'hFF00, a[3:0], 1'b0, ref_rot(16'hFF00, a, 1'b0));
            do_op("sweep l", !a[0], 16'hFF00, a[3:0], 1'b1, ref_rot(16'hFF00, a, 1'b1));
        end

        // Contention from reset: both held, distinct operands.
        reset = 1'b1;
        step();
        req0 = 1'b1; num0 = 16'hA5A5; amt0 = 4'd1; lr0 = 1'b1;
        req1 = 1'b1; num1 = 16'h1234; amt1 = 4'd4; lr1 = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            step();
            check("cont gnt", {gnt0, gnt1}, 2'b10);
            step();
            check("cont done", {done0, done1}, 2'b10);
            check("cont dout", dout, 16'h4B4B);
`else
            step();
            check("cont gnt", {gnt0, gnt1}, i[0] ? 2'b01 : 2'b10);
            step();
            check("cont done", {done0, done1}, i[0] ? 2'b01 : 2'b10);
            check("cont dout", dout, i[0] ? 16'h4123 : 16'h4B4B);
`endif
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        check("cont quiet", {gnt0, gnt1, busy}, 3'b000);

        // Operand change after grant, req0 kept high for a second operation.
        req0 = 1'b1; num0 = 16'h00FF; amt0 = 4'd8; lr0 = 1'b0;
        step();
        check("hs gnt0 a", gnt0, 1'b1);
        num0 = 16'h1234;
        step();
        check("hs done0 a", done0, 1'b1);
        check("hs dout a", dout, 16'hFF00);
        step();
        check("hs gnt0 b", gnt0, 1'b1);
        check("hs busy b", busy, 1'b1);
        req0 = 1'b0;
        step();
        check("hs done0 b", done0, 1'b1);
        check("hs dout b", dout, 16'h3412);

        // Reset during EXEC aborts; pointer reverts so port 0 wins next.
        req0 = 1'b1; num0 = 16'h0F0F; amt0 = 4'd2; lr0 = 1'b1;
        step();
        check("abort gnt0", gnt0, 1'b1);
        check("abort busy", busy, 1'b1);
        req0 = 1'b0;
        reset = 1'b1;
        step();
        check("abort done", {done0, done1}, 2'b00);
        check("abort dout", dout, 16'h0000);
        check("abort busy off", busy, 1'b0);
        reset = 1'b0;
        step();
        check("abort quiet", {done0, done1, gnt0, gnt1}, 4'b0000);
        req0 = 1'b1; num0 = 16'h0001; amt0 = 4'd1; lr0 = 1'b1;
        req1 = 1'b1; num1 = 16'h8000; amt1 = 4'd1; lr1 = 1'b1;
        step();
        check("post-reset gnt", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        check("post-reset done", {done0, done1}, 2'b10);
        check("post-reset dout", dout, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-port arbiter and sequencer for the multifunction rotate datapath (N-bit word, M-bit amount, left/right select). It lets two independent requesters share one rotate unit, holds the winning operands in registers, performs the rotation and returns a registered result with a per-port completion pulse. It sits between the requesting datapaths and the shared rotate logic, which is instantiated inside this block.

## Interface

Parameters:
- N, 16, data width in bits; must equal 2**M.
- M, 4, rotate-amount width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request (level).
- num0  input  N  port 0 operand.
- amt0  input  M  port 0 rotate amount.
- lr0  input  1  port 0 direction: 0 = rotate right, 1 = rotate left.
- req1, num1, amt1, lr1  input  1/N/M/1  port 1 equivalents.
- gnt0  output  1  one-cycle pulse: port 0 operands captured.
- gnt1  output  1  one-cycle pulse: port 1 operands captured.
- done0  output  1  one-cycle pulse: dout holds the port 0 result.
- done1  output  1  one-cycle pulse: dout holds the port 1 result.
- dout  output  N  registered rotate result; holds its value until the next completion.
- busy  output  1  high while an operation is in flight (state EXEC).

## Operation

- FSM states:
  - IDLE: if any req is high, select a winner, latch its num/amt/lr into operand registers, assert the matching gnt next cycle and go to EXEC. Otherwise stay in IDLE.
  - EXEC: rotate the latched operands, register the result into dout, assert the matching done next cycle and return to IDLE.
- Rotation: circular, with no bits lost. The amount is taken modulo N (the full M-bit range is used). amt = 0 passes the operand through unchanged.
- Arbitration (default round-robin):
  - A last-served pointer is updated on each grant.
  - If only one port requests, it wins.
  - If both request, the port not served last wins.
  - Reset value of the pointer is "port 1 served last", so port 0 wins the first contention.
- Handshake:
  - The requester holds req and its operands stable until it sees gnt.
  - It must drop req on the clock edge following gnt.
  - A req still high in the next IDLE cycle is treated as a new request.
  - Operand changes after gnt have no effect on the in-flight operation.
- Requests arriving in EXEC are ignored until IDLE. There is no queueing beyond the req level itself.
- Only one gnt and one done can be high in any cycle; gnt0/gnt1 and done0/done1 are mutually exclusive.

## Timing

- Reset values: gnt0 = gnt1 = done0 = done1 = 0, dout = 0, busy = 0, state = IDLE, pointer = port 1.
- Request sampled in IDLE at edge k:
  - gnt and busy are high in cycle k+1.
  - done is high and dout is valid from edge k+2; dout stays stable until the next done.
  - busy is low again in cycle k+2.
- Latency is 2 cycles from request sample to done. Maximum throughput is one operation per 2 cycles.
- Back-to-back: with both req held, grants alternate 0,1,0,1 on every second cycle; each port is served within 4 cycles of requesting.
- Reset asserted in EXEC aborts the operation:
  - No done is issued.
  - dout is cleared to 0.
  - The pointer reverts to port 1.
- Reset has priority over all other events in the same cycle.

## Configuration

- SHIFT_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Port 0 always wins contention, the last-served pointer is not implemented, and port 1 is served only when req0 is low in IDLE.
  - Undefined (default): round-robin as described above.

## Test plan

- Single request, port 0: num0 = 16'hFF00, amt0 = 4, lr0 = 0 -> gnt0 at k+1, done0 at k+2, dout = 16'h0FF0, busy high only at k+1.
- Port 1 left rotate: num1 = 16'hFF00, amt1 = 4, lr1 = 1 -> done1, dout = 16'hF00F. Repeat with amt1 = 0 -> dout = 16'hFF00; amt1 = 15 -> dout = 16'h7F80.
- Sweep amt 0..15 in both directions on 16'hFF00 -> each dout equals the reference circular rotate; no bit loss.
- Contention: req0 and req1 held continuously from reset with distinct operands -> grants 0,1,0,1; each done is paired with the correct port's result. With SHIFT_ARB_FIXED_PRIO_EN defined -> only port 0 is served while req0 stays high.
- Handshake robustness: change num0 to 16'h1234 in the cycle after gnt0 -> dout reflects the originally latched operand; req0 kept high -> a second operation is granted at the next IDLE.
- Reset mid-operation: assert reset during EXEC -> no done pulse, dout = 0, busy = 0. The next contention after reset is granted to port 0.
